// File: rtl/sudoku_cursor_ctrl.sv
// Keyboard-driven (row, column) cursor for the Sudoku grid: press-edge detect, hold-to-repeat, edge wrap/saturate, home.
// Latency 1 cycle from key to position/pulses; no backpressure, every key sample is consumed.
module sudoku_cursor_ctrl #(
    parameter int GRID_N        = 9,
    parameter int COORD_W       = 4,
    parameter int WRAP          = 0,
    parameter int REPEAT_DELAY  = 25000000,
    parameter int REPEAT_PERIOD = 5000000
) (
    input  logic               clock,
    input  logic               reset,
    input  logic [3:0]         key_input,
    output logic [COORD_W-1:0] grid_i,
    output logic [COORD_W-1:0] grid_j,
    output logic               move_pulse,
    output logic               blocked_pulse
);

    localparam int CNT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int CW      = $clog2(CNT_MAX + 1);
    localparam logic [CW-1:0]      DLY_END = CW'(REPEAT_DELAY);
    localparam logic [CW-1:0]      PER_END = CW'(REPEAT_PERIOD);
    localparam logic [COORD_W-1:0] MAX_C   = COORD_W'(GRID_N - 1);
    localparam logic [COORD_W-1:0] ZERO_C  = '0;

    typedef enum logic [1:0] {IDLE, DELAY, REPEAT, HELD} state_t;

    state_t              state;
    logic [3:0]          k;
    logic [3:0]          key_prev;
    logic [CW-1:0]       cnt;
    logic [CW-1:0]       cnt_inc;
    logic                press;
    logic                fire;
    logic [COORD_W-1:0]  nxt_i;
    logic [COORD_W-1:0]  nxt_j;
    logic                act_move;
    logic                act_blk;

    // Unused codes behave exactly like "no key", including for press-edge detection.
    assign k       = (key_input > 4'd5) ? 4'd0 : key_input;
    assign press   = (k != 4'd0) && (k != key_prev);
    assign cnt_inc = cnt + CW'(1);

    always_comb begin
        fire = 1'b0;
        if (k != 4'd0) begin
            if (press)
                fire = 1'b1;
            else if (state == DELAY)
                fire = (cnt_inc == DLY_END);
            else if (state == REPEAT)
                fire = (cnt_inc == PER_END);
        end
    end

    // Boundary test precedes every add/subtract so the coordinate can never overflow.
    always_comb begin
        nxt_i   = grid_i;
        nxt_j   = grid_j;
        act_blk = 1'b0;
        case (k)
            4'd1: if (grid_i == MAX_C) begin
                      if (WRAP != 0) nxt_i = ZERO_C; else act_blk = 1'b1;
                  end else nxt_i = grid_i + COORD_W'(1);
            4'd3: if (grid_i == ZERO_C) begin
                      if (WRAP != 0) nxt_i = MAX_C; else act_blk = 1'b1;
                  end else nxt_i = grid_i - COORD_W'(1);
            4'd4: if (grid_j == MAX_C) begin
                      if (WRAP != 0) nxt_j = ZERO_C; else act_blk = 1'b1;
                  end else nxt_j = grid_j + COORD_W'(1);
            4'd2: if (grid_j == ZERO_C) begin
                      if (WRAP != 0) nxt_j = MAX_C; else act_blk = 1'b1;
                  end else nxt_j = grid_j - COORD_W'(1);
            4'd5: begin
                      nxt_i = ZERO_C;
                      nxt_j = ZERO_C;
                  end
            default: ;
        endcase
        act_move = (nxt_i != grid_i) || (nxt_j != grid_j);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            grid_i        <= '0;
            grid_j        <= '0;
            move_pulse    <= 1'b0;
            blocked_pulse <= 1'b0;
            key_prev      <= 4'd0;
            cnt           <= '0;
            state         <= IDLE;
        end else begin
            key_prev      <= k;
            move_pulse    <= 1'b0;
            blocked_pulse <= 1'b0;
            if (fire) begin
                grid_i        <= nxt_i;
                grid_j        <= nxt_j;
                move_pulse    <= act_move;
                blocked_pulse <= act_blk;
            end
            if (k == 4'd0) begin
                state <= IDLE;
                cnt   <= '0;
            end else if (press) begin
                cnt   <= '0;
                state <= (k != 4'd5 && REPEAT_DELAY > 0) ? DELAY : HELD;
            end else begin
                case (state)
                    DELAY: begin
                        if (cnt_inc == DLY_END) begin
                            cnt   <= '0;
                            state <= REPEAT;
                        end else begin
                            cnt <= cnt_inc;
                        end
                    end
                    REPEAT: cnt <= (cnt_inc == PER_END) ? '0 : cnt_inc;
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_sudoku_cursor_ctrl.sv
// Two cursors (saturating and wrapping) driven from hand-built key/expectation tables through a scoreboard queue.
module tb_sudoku_cursor_ctrl;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic [3:0] key_a = 4'd0;
    logic [3:0] key_b = 4'd0;
    logic [3:0] ai, aj, bi, bj;
    logic       am, ab, bm, bbk;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [3:0] ka, kb;
        logic [3:0] ai, aj;
        logic       am, ab;
        logic [3:0] bi, bj;
        logic       bm, bb;
    } ent_t;

    ent_t stim_q[$];
    ent_t exp_q[$];
    ent_t e, x;
    logic [3:0] ra_i = 0, ra_j = 0, rb_i = 0, rb_j = 0;

    always #5 clock = ~clock;

    sudoku_cursor_ctrl #(.GRID_N(9), .COORD_W(4), .WRAP(0), .REPEAT_DELAY(4), .REPEAT_PERIOD(2)) dut_a (
        .clock(clock), .reset(reset), .key_input(key_a),
        .grid_i(ai), .grid_j(aj), .move_pulse(am), .blocked_pulse(ab));

    sudoku_cursor_ctrl #(.GRID_N(9), .COORD_W(4), .WRAP(1), .REPEAT_DELAY(4), .REPEAT_PERIOD(2)) dut_b (
        .clock(clock), .reset(reset), .key_input(key_b),
        .grid_i(bi), .grid_j(bj), .move_pulse(bm), .blocked_pulse(bbk));

    // Saturating cursor gets key k, wrapping cursor idles at its last position.
    task automatic sa(input logic [3:0] k, input logic [3:0] i, input logic [3:0] j, input logic m, input logic b);
        stim_q.push_back('{ka:k, kb:4'd0, ai:i, aj:j, am:m, ab:b, bi:rb_i, bj:rb_j, bm:1'b0, bb:1'b0});
        ra_i = i;
        ra_j = j;
    endtask

    task automatic sb(input logic [3:0] k, input logic [3:0] i, input logic [3:0] j, input logic m, input logic b);
        stim_q.push_back('{ka:4'd0, kb:k, ai:ra_i, aj:ra_j, am:1'b0, ab:1'b0, bi:i, bj:j, bm:m, bb:b});
        rb_i = i;
        rb_j = j;
    endtask

    task automatic test_reset;
        #3;
        checks++;
        if ({ai, aj, am, ab, bi, bj, bm, bbk} !== 20'd0) begin
            errors++;
            $display("FAIL reset: got a=(%0d,%0d,m%b,b%b) b=(%0d,%0d,m%b,b%b) want all zero", ai, aj, am, ab, bi, bj, bm, bbk);
        end
        @(posedge clock); #1;
        reset = 1'b0;
        @(posedge clock); #1;
        checks++;
        if ({ai, aj, am, ab, bi, bj, bm, bbk} !== 20'd0) begin
            errors++;
            $display("FAIL reset_release: got a=(%0d,%0d,m%b,b%b) b=(%0d,%0d,m%b,b%b) want all zero", ai, aj, am, ab, bi, bj, bm, bbk);
        end
    endtask

    task automatic test_single_press;
        sa(1, 1, 0, 1, 0);
        sa(0, 1, 0, 0, 0);
        sa(0, 1, 0, 0, 0);
        while (stim_q.size() > 0) begin
            e = stim_q.pop_front();
            key_a = e.ka; key_b = e.kb; exp_q.push_back(e);
            @(posedge clock); #1;
            x = exp_q.pop_front();
            checks++;
            if ({ai, aj, am, ab, bi, bj, bm, bbk} !== {x.ai, x.aj, x.am, x.ab, x.bi, x.bj, x.bm, x.bb}) begin
                errors++;
                $display("FAIL single_press: got a=(%0d,%0d,m%b,b%b) b=(%0d,%0d,m%b,b%b) want a=(%0d,%0d,m%b,b%b) b=(%0d,%0d,m%b,b%b)",
                         ai, aj, am, ab, bi, bj, bm, bbk, x.ai, x.aj, x.am, x.ab, x.bi, x.bj, x.bm, x.bb);
            end
        end
    endtask

    task automatic test_auto_repeat;
        sa(5, 0, 0, 1, 0);
        sa(0, 0, 0, 0, 0);
        sa(1, 1, 0, 1, 0);
        sa(1, 1, 0, 0, 0);
        sa(1, 1, 0, 0, 0);
        sa(1, 1, 0, 0, 0);
        sa(1, 2, 0, 1, 0);
        sa(1, 2, 0, 0, 0);
        sa(1, 3, 0, 1, 0);
        sa(1, 3, 0, 0, 0);
        sa(1, 4, 0, 1, 0);
        sa(0, 4, 0, 0, 0);
        while (stim_q.size() > 0) begin
            e = stim_q.pop_front();
            key_a = e.ka; key_b = e.kb; exp_q.push_back(e);
            @(posedge clock); #1;
            x = exp_q.pop_front();
            checks++;
            if ({ai, aj, am, ab, bi, bj, bm, bbk} !== {x.ai, x.aj, x.am, x.ab, x.bi, x.bj, x.bm, x.bb}) begin
                errors++;
                $display("FAIL auto_repeat: got a=(%0d,%0d,m%b,b%b) b=(%0d,%0d,m%b,b%b) want a=(%0d,%0d,m%b,b%b) b=(%0d,%0d,m%b,b%b)",
                         ai, aj, am, ab, bi, bj, bm, bbk, x.ai, x.aj, x.am, x.ab, x.bi, x.bj, x.bm, x.bb);
            end
        end
    endtask

    task automatic test_edges;
        for (int n = 5; n <= 8; n++) begin
            sa(1, 4'(n), 0, 1, 0);
            sa(0, 4'(n), 0, 0, 0);
        end
        sa(1, 8, 0, 0, 1);
        sa(0, 8, 0, 0, 0);
        sa(2, 8, 0, 0, 1);
        sa(0, 8, 0, 0, 0);
        sb(3, 8, 0, 1, 0);
        sb(0, 8, 0, 0, 0);
        sb(1, 0, 0, 1, 0);
        sb(0, 0, 0, 0, 0);
        while (stim_q.size() > 0) begin
            e = stim_q.pop_front();
            key_a = e.ka; key_b = e.kb; exp_q.push_back(e);
            @(posedge clock); #1;
            x = exp_q.pop_front();
            checks++;
            if ({ai, aj, am, ab, bi, bj, bm, bbk} !== {x.ai, x.aj, x.am, x.ab, x.bi, x.bj, x.bm, x.bb}) begin
                errors++;
                $display("FAIL edges: got a=(%0d,%0d,m%b,b%b) b=(%0d,%0d,m%b,b%b) want a=(%0d,%0d,m%b,b%b) b=(%0d,%0d,m%b,b%b)",
                         ai, aj, am, ab, bi, bj, bm, bbk, x.ai, x.aj, x.am, x.ab, x.bi, x.bj, x.bm, x.bb);
            end
        end
    endtask

    task automatic test_wrap_j;
        sb(2, 0, 8, 1, 0);
        sb(0, 0, 8, 0, 0);
        sb(4, 0, 0, 1, 0);
        sb(0, 0, 0, 0, 0);
        while (stim_q.size() > 0) begin
            e = stim_q.pop_front();
            key_a = e.ka; key_b = e.kb; exp_q.push_back(e);
            @(posedge clock); #1;
            x = exp_q.pop_front();
            checks++;
            if ({ai, aj, am, ab, bi, bj, bm, bbk} !== {x.ai, x.aj, x.am, x.ab, x.bi, x.bj, x.bm, x.bb}) begin
                errors++;
                $display("FAIL wrap_j: got a=(%0d,%0d,m%b,b%b) b=(%0d,%0d,m%b,b%b) want a=(%0d,%0d,m%b,b%b) b=(%0d,%0d,m%b,b%b)",
                         ai, aj, am, ab, bi, bj, bm, bbk, x.ai, x.aj, x.am, x.ab, x.bi, x.bj, x.bm, x.bb);
            end
        end
    endtask

    task automatic test_back_to_back;
        sa(5, 0, 0, 1, 0);
        sa(0, 0, 0, 0, 0);
        sa(1, 1, 0, 1, 0);
        sa(1, 1, 0, 0, 0);
        sa(1, 1, 0, 0, 0);
        // Direct 1 -> 4 change: immediate j move, then the full delay again.
        sa(4, 1, 1, 1, 0);
        sa(4, 1, 1, 0, 0);
        sa(4, 1, 1, 0, 0);
        sa(4, 1, 1, 0, 0);
        sa(4, 1, 2, 1, 0);
        sa(4, 1, 2, 0, 0);
        sa(4, 1, 3, 1, 0);
        sa(0, 1, 3, 0, 0);
        sa(1, 2, 3, 1, 0); sa(0, 2, 3, 0, 0);
        sa(1, 3, 3, 1, 0); sa(0, 3, 3, 0, 0);
        sa(4, 3, 4, 1, 0); sa(0, 3, 4, 0, 0);
        sa(4, 3, 5, 1, 0); sa(0, 3, 5, 0, 0);
        sa(5, 0, 0, 1, 0);
        for (int n = 0; n < 9; n++) sa(5, 0, 0, 0, 0);
        sa(0, 0, 0, 0, 0);
        sa(5, 0, 0, 0, 0);
        sa(0, 0, 0, 0, 0);
        while (stim_q.size() > 0) begin
            e = stim_q.pop_front();
            key_a = e.ka; key_b = e.kb; exp_q.push_back(e);
            @(posedge clock); #1;
            x = exp_q.pop_front();
            checks++;
            if ({ai, aj, am, ab, bi, bj, bm, bbk} !== {x.ai, x.aj, x.am, x.ab, x.bi, x.bj, x.bm, x.bb}) begin
                errors++;
                $display("FAIL back_to_back: got a=(%0d,%0d,m%b,b%b) b=(%0d,%0d,m%b,b%b) want a=(%0d,%0d,m%b,b%b) b=(%0d,%0d,m%b,b%b)",
                         ai, aj, am, ab, bi, bj, bm, bbk, x.ai, x.aj, x.am, x.ab, x.bi, x.bj, x.bm, x.bb);
            end
        end
    endtask

    task automatic test_reset_mid_hold;
        stim_q.push_back('{ka:1, kb:4, ai:1, aj:0, am:1, ab:0, bi:0, bj:1, bm:1, bb:0});
        stim_q.push_back('{ka:1, kb:4, ai:1, aj:0, am:0, ab:0, bi:0, bj:1, bm:0, bb:0});
        stim_q.push_back('{ka:1, kb:4, ai:1, aj:0, am:0, ab:0, bi:0, bj:1, bm:0, bb:0});
        while (stim_q.size() > 0) begin
            e = stim_q.pop_front();
            key_a = e.ka; key_b = e.kb; exp_q.push_back(e);
            @(posedge clock); #1;
            x = exp_q.pop_front();
            checks++;
            if ({ai, aj, am, ab, bi, bj, bm, bbk} !== {x.ai, x.aj, x.am, x.ab, x.bi, x.bj, x.bm, x.bb}) begin
                errors++;
                $display("FAIL hold_before_reset: got a=(%0d,%0d,m%b,b%b) b=(%0d,%0d,m%b,b%b) want a=(%0d,%0d,m%b,b%b) b=(%0d,%0d,m%b,b%b)",
                         ai, aj, am, ab, bi, bj, bm, bbk, x.ai, x.aj, x.am, x.ab, x.bi, x.bj, x.bm, x.bb);
            end
        end
        #2 reset = 1'b1;
        #1;
        checks++;
        if ({ai, aj, am, ab, bi, bj, bm, bbk} !== 20'd0) begin
            errors++;
            $display("FAIL async_reset: got a=(%0d,%0d,m%b,b%b) b=(%0d,%0d,m%b,b%b) want all zero", ai, aj, am, ab, bi, bj, bm, bbk);
        end
        @(posedge clock); #1;
        reset = 1'b0;
        stim_q.push_back('{ka:1, kb:4, ai:1, aj:0, am:1, ab:0, bi:0, bj:1, bm:1, bb:0});
        for (int n = 0; n < 3; n++)
            stim_q.push_back('{ka:1, kb:4, ai:1, aj:0, am:0, ab:0, bi:0, bj:1, bm:0, bb:0});
        stim_q.push_back('{ka:1, kb:4, ai:2, aj:0, am:1, ab:0, bi:0, bj:2, bm:1, bb:0});
        stim_q.push_back('{ka:0, kb:0, ai:2, aj:0, am:0, ab:0, bi:0, bj:2, bm:0, bb:0});
        ra_i = 2; ra_j = 0; rb_i = 0; rb_j = 2;
        for (int c = 6; c <= 15; c++) begin
            sa(4'(c), 2, 0, 0, 0);
            sa(4'(c), 2, 0, 0, 0);
        end
        // An unused code between two 1s acts as a release, so the second 1 is a fresh press.
        sa(1, 3, 0, 1, 0);
        sa(9, 3, 0, 0, 0);
        sa(1, 4, 0, 1, 0);
        sa(0, 4, 0, 0, 0);
        while (stim_q.size() > 0) begin
            e = stim_q.pop_front();
            key_a = e.ka; key_b = e.kb; exp_q.push_back(e);
            @(posedge clock); #1;
            x = exp_q.pop_front();
            checks++;
            if ({ai, aj, am, ab, bi, bj, bm, bbk} !== {x.ai, x.aj, x.am, x.ab, x.bi, x.bj, x.bm, x.bb}) begin
                errors++;
                $display("FAIL after_reset: got a=(%0d,%0d,m%b,b%b) b=(%0d,%0d,m%b,b%b) want a=(%0d,%0d,m%b,b%b) b=(%0d,%0d,m%b,b%b)",
                         ai, aj, am, ab, bi, bj, bm, bbk, x.ai, x.aj, x.am, x.ab, x.bi, x.bj, x.bm, x.bb);
            end
        end
    endtask

    initial begin
        test_reset;
        test_single_press;
        test_auto_repeat;
        test_edges;
        test_wrap_j;
        test_back_to_back;
        test_reset_mid_hold;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/sudoku_cursor_ctrl.md
Name: sudoku_cursor_ctrl

Overview:
Parametrised cursor controller for the Sudoku grid. It replaces the fixed 9x9 level-driven cursor. It converts keyboard direction codes into a registered (row, column) cursor position and adds:
- press-edge detection
- hold-to-auto-repeat
- optional wrap-around at the grid edges
- a home command
- move/blocked status pulses
It sits between the keyboard decoder and the board/display logic.

Parameters:
GRID_N, 9, cells per grid side; legal range 2..(2**COORD_W).
COORD_W, 4, width of each cursor coordinate.
WRAP, 0, 0 = saturate at edges, 1 = wrap to the opposite edge.
REPEAT_DELAY, 25000000, clock edges a key must be held before the first auto-repeat; 0 disables auto-repeat.
REPEAT_PERIOD, 5000000, clock edges between successive auto-repeats; must be >= 1.

Ports:
clock  in  1  system clock; all state changes on its rising edge.
reset  in  1  asynchronous, active-high reset.
key_input  in  4  key code: 0 none, 1 W (i+1), 2 D (j-1), 3 S (i-1), 4 A (j+1), 5 home; codes 6..15 are treated as 0.
grid_i  out  COORD_W  cursor row, registered.
grid_j  out  COORD_W  cursor column, registered.
move_pulse  out  1  high for one cycle after an action that changed the position.
blocked_pulse  out  1  high for one cycle after a move refused at an edge (WRAP=0 only).

Behaviour:
- Reset (asynchronous, active-high):
  - grid_i = 0, grid_j = 0, move_pulse = 0, blocked_pulse = 0.
  - key_prev = 0, repeat counter = 0, state = IDLE.
  - Reset asserted mid-hold aborts the repeat. After release, a still-held key counts as a new press only if it differs from key_prev (0). A held nonzero key therefore fires once after reset.
- Key code k = key_input with 6..15 mapped to 0. The key_prev register holds the last sampled k.
- Press: at an edge where k != 0 and k != key_prev.
  - The action executes at that edge; outputs are visible one cycle after k is applied.
  - A direct change from one nonzero code to another is a new press.
- Release: at an edge where k = 0. Go to IDLE; no action.
- State IDLE:
  - On press: execute the action and clear the counter.
  - Go to DELAY if k is 1..4 and REPEAT_DELAY > 0; otherwise go to HELD.
- State DELAY (same k held):
  - Counter increments each edge.
  - At the edge where the counter reaches REPEAT_DELAY, execute the action, clear the counter and go to REPEAT.
  - So the first repeat fires exactly REPEAT_DELAY edges after the press edge.
- State REPEAT (same k held): execute the action every REPEAT_PERIOD edges after the previous action.
- State HELD: no action until release or a new press. Home (5) never repeats.
- In any non-IDLE state, a new press restarts the sequence as in IDLE.
- Actions:
  - Code 1 increments i; code 3 decrements i.
  - Code 4 increments j; code 2 decrements j.
  - Code 5 sets i = 0, j = 0.
- Edge handling:
  - Increment at GRID_N-1 or decrement at 0 with WRAP=0: position is held and blocked_pulse = 1.
  - Same case with WRAP=1: wrap to 0 or GRID_N-1 respectively; move_pulse = 1.
- move_pulse is 1 only when the new position differs from the old one. Home at (0,0) gives both pulses 0.
- Both pulses default to 0 on every edge without an action. They are never high simultaneously.
- Only one axis changes per action. i and j never leave 0..GRID_N-1.
- Arithmetic is done in COORD_W bits, with the boundary compare done before any add or subtract, so no overflow is possible.
- Counter width is clog2(max(REPEAT_DELAY, REPEAT_PERIOD) + 1).

Test Plan:
Use GRID_N=9, WRAP=0, REPEAT_DELAY=4, REPEAT_PERIOD=2 unless noted.
1. Reset, then key 1 for 1 cycle, then 0 -> grid_i = 1 one cycle later; move_pulse high for exactly 1 cycle; grid_j = 0.
2. Key 1 held 9 cycles from (0,0) -> moves at press edges 0, 4, 6, 8 -> grid_i = 4; four move pulses.
3. From (8,0), key 1 pressed -> grid_i stays 8; blocked_pulse = 1. With WRAP=1 -> grid_i = 0 and move_pulse = 1.
4. From (0,0), key 2 pressed with WRAP=1 -> grid_j = 8. Then key 4 pressed -> grid_j = 0.
5. Key 1 held, then key 4 applied directly with no 0 in between -> j increments on the change edge; the repeat delay restarts (next j move 4 edges later). Key 5 held 10 cycles at (3,5) -> (0,0) once; no repeat.
6. Key 1 held with reset asserted asynchronously mid-DELAY -> outputs go to 0 immediately. After reset release with key 1 still held -> one press-move to grid_i = 1; the repeat sequence restarts. Codes 6..15 held -> no change, no pulses.
